if_fetch_stage: RTL and testbench



---
 rtl/riscv_pkg.sv | 11 +
 rtl/if_fetch_stage_fetch_queue.sv | 70 +++++++
 rtl/if_fetch_stage.sv | 178 +++++++++++++++++
 tb/tb_if_fetch_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 constants and the fetch-stage state type.
package riscv_pkg;
    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;
endpackage

// File: rtl/if_fetch_stage_fetch_queue.sv
// fetch_queue: synchronous FIFO of {instr, pc} pairs with flush and occupancy count.
module fetch_queue #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_instr,
    input  logic [W-1:0]             push_pc,
    input  logic                     pop,
    input  logic                     flush,
    output logic [W-1:0]             head_instr,
    output logic [W-1:0]             head_pc,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_instr_r [DEPTH];
    logic [W-1:0]  mem_pc_r    [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; written at the tail on every push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr_r[i] <= {W{1'b0}};
                mem_pc_r[i]    <= {W{1'b0}};
            end
        end else if (push && !flush) begin
            mem_instr_r[wr_ptr_r] <= push_instr;
            mem_pc_r[wr_ptr_r]    <= push_pc;
        end else begin
            mem_instr_r[wr_ptr_r] <= mem_instr_r[wr_ptr_r];
            mem_pc_r[wr_ptr_r]    <= mem_pc_r[wr_ptr_r];
        end
    end

    assign head_instr = mem_instr_r[rd_ptr_r];
    assign head_pc    = mem_pc_r[rd_ptr_r];
    assign count      = count_r;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC, 1-cycle imem request issue, fetch queue and redirect handling.
// Optional misaligned-redirect trap (HALT state, misalign_o) under IF_FETCH_MISALIGN_TRAP_EN.
module if_fetch_stage
    import riscv_pkg::*;
#(
    parameter int                    DATA_WIDTH = XLEN,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT),
    parameter int                    QDEPTH     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_rd_en_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pc_plus4_o
`ifdef IF_FETCH_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_o
`endif
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic [DATA_WIDTH-1:0] pc_r;
    logic [DATA_WIDTH-1:0] fetch_addr_r;
    logic                  inflight_r;
    logic [DATA_WIDTH-1:0] pc_nxt_s;
    logic                  inflight_nxt_s;
    logic [DATA_WIDTH-1:0] redirect_pc_s;
    logic                  redirect_ok_s;
    logic                  fetch_en_s;
    logic                  rd_en_s;
    logic [DATA_WIDTH-1:0] rd_addr_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  flush_s;
    logic                  valid_s;
    logic                  room_s;
    logic [CW-1:0]         count_s;
    logic [CW:0]           occ_s;
    logic [CW:0]           lim_s;
    logic [DATA_WIDTH-1:0] head_instr_s;
    logic [DATA_WIDTH-1:0] head_pc_s;

`ifdef IF_FETCH_MISALIGN_TRAP_EN
    fetch_state_e state_r;
    fetch_state_e state_s;
    logic         misalign_r;

    assign redirect_pc_s = redirect_pc_i;
    assign redirect_ok_s = (redirect_pc_i[1:0] == 2'b00);
    assign fetch_en_s    = (state_r == RUN);
    assign misalign_o    = misalign_r;

    // Trap state register; misalign_o mirrors HALT one cycle after the redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= RUN;
            misalign_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            misalign_r <= (state_s == HALT);
        end
    end

    // Only redirects move between RUN and HALT.
    always_comb begin
        state_s = state_r;
        case (state_r)
            RUN: begin
                if (redirect_i && !redirect_ok_s) state_s = HALT;
                else                              state_s = RUN;
            end
            HALT: begin
                if (redirect_i && redirect_ok_s) state_s = RUN;
                else                             state_s = HALT;
            end
            default: state_s = RUN;
        endcase
    end
`else
    assign redirect_pc_s = redirect_pc_i & ~DATA_WIDTH'(3);
    assign redirect_ok_s = 1'b1;
    assign fetch_en_s    = 1'b1;
`endif

    assign valid_s = (count_s != {CW{1'b0}}) & ~rst;
    assign pop_s   = valid_s & ~stall_i;
    // One slot is reserved for every read still in flight.
    assign occ_s   = {1'b0, count_s} + {{CW{1'b0}}, inflight_r};
    assign lim_s   = (CW+1)'(QDEPTH) + {{CW{1'b0}}, pop_s};
    assign room_s  = (occ_s < lim_s);

    // Issue, response-push and redirect decisions.
    always_comb begin
        rd_en_s        = 1'b0;
        rd_addr_s      = {DATA_WIDTH{1'b0}};
        pc_nxt_s       = pc_r;
        inflight_nxt_s = 1'b0;
        push_s         = 1'b0;
        flush_s        = 1'b0;
        if (rst) begin
            rd_en_s = 1'b0;
        end else if (redirect_i) begin
            flush_s = 1'b1;
            if (redirect_ok_s) begin
                rd_en_s        = 1'b1;
                rd_addr_s      = redirect_pc_s;
                pc_nxt_s       = redirect_pc_s + DATA_WIDTH'(4);
                inflight_nxt_s = 1'b1;
            end else begin
                inflight_nxt_s = 1'b0;
            end
        end else begin
            push_s = inflight_r;
            if (fetch_en_s && room_s) begin
                rd_en_s        = 1'b1;
                rd_addr_s      = pc_r;
                pc_nxt_s       = pc_r + DATA_WIDTH'(4);
                inflight_nxt_s = 1'b1;
            end else begin
                inflight_nxt_s = 1'b0;
            end
        end
    end

    // PC, in-flight flag and the address of the outstanding read.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r         <= RESET_PC;
            inflight_r   <= 1'b0;
            fetch_addr_r <= {DATA_WIDTH{1'b0}};
        end else begin
            pc_r       <= pc_nxt_s;
            inflight_r <= inflight_nxt_s;
            if (rd_en_s) fetch_addr_r <= rd_addr_s;
            else         fetch_addr_r <= fetch_addr_r;
        end
    end

    fetch_queue #(
        .W     (DATA_WIDTH),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .push_instr (imem_rdata_i),
        .push_pc    (fetch_addr_r),
        .pop        (pop_s),
        .flush      (flush_s),
        .head_instr (head_instr_s),
        .head_pc    (head_pc_s),
        .count      (count_s)
    );

    assign imem_rd_en_o = rd_en_s;
    assign imem_addr_o  = rd_addr_s;
    assign valid_o      = valid_s;

    // Head presentation; empty queue shows a NOP at PC 0.
    always_comb begin
        if (valid_s) begin
            instr_o    = head_instr_s;
            pc_o       = head_pc_s;
            pc_plus4_o = head_pc_s + DATA_WIDTH'(4);
        end else begin
            instr_o    = DATA_WIDTH'(NOP_INSTR);
            pc_o       = {DATA_WIDTH{1'b0}};
            pc_plus4_o = {DATA_WIDTH{1'b0}};
        end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage (RESET_PC=0x100, QDEPTH=2); imem returns addr ^ 0xA5A5_0000.
module tb_if_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_rd_en_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
`ifdef IF_FETCH_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_fetch_stage #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0000_0100),
        .QDEPTH     (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_rd_en_o  (imem_rd_en_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .valid_o       (valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o)
`ifdef IF_FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_o    (misalign_o)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Advance one clock; the instruction memory answers a request one cycle later.
    task automatic step();
        logic        req;
        logic [31:0] a;
        req = imem_rd_en_o;
        a   = imem_addr_o;
        @(posedge clk);
        #1;
        imem_rdata_i = req ? mem_word(a) : 32'hDEAD_BEEF;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        imem_rdata_i = 32'hDEAD_BEEF;
        step(); step(); #1;
        total++; if (imem_rd_en_o !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b exp=0", imem_rd_en_o); end
        total++; if (imem_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        total++; if (instr_o !== 32'h0000_0013) begin bad++; $display("FAIL reset_instr got=%h exp=00000013", instr_o); end
        total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc_o); end
        total++; if (pc_plus4_o !== 32'h0) begin bad++; $display("FAIL reset_pc4 got=%h exp=0", pc_plus4_o); end
    endtask

    task automatic test_startup();
        rst = 1'b0; #1;
        total++; if (imem_rd_en_o !== 1'b1 || imem_addr_o !== 32'h100) begin bad++; $display("FAIL c0_req got=%b/%h exp=1/00000100", imem_rd_en_o, imem_addr_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL c0_valid got=%b exp=0", valid_o); end
        step(); #1;
        total++; if (imem_rd_en_o !== 1'b1 || imem_addr_o !== 32'h104) begin bad++; $display("FAIL c1_req got=%b/%h exp=1/00000104", imem_rd_en_o, imem_addr_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL c1_valid got=%b exp=0", valid_o); end
        step(); #1;
        total++; if (imem_addr_o !== 32'h108) begin bad++; $display("FAIL c2_addr got=%h exp=00000108", imem_addr_o); end
        total++; if (valid_o !== 1'b1 || pc_o !== 32'h100) begin bad++; $display("FAIL c2_head got=%b/%h exp=1/00000100", valid_o, pc_o); end
        total++; if (pc_plus4_o !== 32'h104) begin bad++; $display("FAIL c2_pc4 got=%h exp=00000104", pc_plus4_o); end
        total++; if (instr_o !== 32'hA5A5_0100) begin bad++; $display("FAIL c2_instr got=%h exp=a5a50100", instr_o); end
        step();
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc;
        for (int c = 0; c < 5; c++) begin
            stall_i = 1'b1; #1;
            total++; if (valid_o !== 1'b1 || pc_o !== 32'h104) begin bad++; $display("FAIL stall_head c=%0d got=%b/%h exp=1/00000104", c, valid_o, pc_o); end
            total++; if (instr_o !== 32'hA5A5_0104) begin bad++; $display("FAIL stall_instr c=%0d got=%h exp=a5a50104", c, instr_o); end
            total++; if (imem_rd_en_o !== 1'b0) begin bad++; $display("FAIL stall_rd_en c=%0d got=%b exp=0", c, imem_rd_en_o); end
            step();
        end
        stall_i = 1'b0;
        exp_pc = 32'h104;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (valid_o !== 1'b1 || pc_o !== exp_pc) begin bad++; $display("FAIL release_pc k=%0d got=%b/%h exp=1/%h", k, valid_o, pc_o, exp_pc); end
            total++; if (instr_o !== mem_word(exp_pc)) begin bad++; $display("FAIL release_instr k=%0d got=%h exp=%h", k, instr_o, mem_word(exp_pc)); end
            if (k == 0) begin
                total++; if (imem_rd_en_o !== 1'b1 || imem_addr_o !== 32'h10C) begin bad++; $display("FAIL refill_req got=%b/%h exp=1/0000010c", imem_rd_en_o, imem_addr_o); end
            end
            exp_pc = exp_pc + 32'd4;
            step();
        end
    endtask

    task automatic test_redirect();
        redirect_i = 1'b1; redirect_pc_i = 32'h200; #1;
        total++; if (imem_rd_en_o !== 1'b1 || imem_addr_o !== 32'h200) begin bad++; $display("FAIL redir_req got=%b/%h exp=1/00000200", imem_rd_en_o, imem_addr_o); end
        step(); redirect_i = 1'b0; #1;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL redir_bubble got=%b exp=0", valid_o); end
        total++; if (imem_addr_o !== 32'h204) begin bad++; $display("FAIL redir_next_addr got=%h exp=00000204", imem_addr_o); end
        step(); #1;
        total++; if (valid_o !== 1'b1 || pc_o !== 32'h200) begin bad++; $display("FAIL redir_head got=%b/%h exp=1/00000200", valid_o, pc_o); end
        total++; if (instr_o !== 32'hA5A5_0200 || pc_plus4_o !== 32'h204) begin bad++; $display("FAIL redir_instr got=%h/%h exp=a5a50200/00000204", instr_o, pc_plus4_o); end
        step(); #1;
        total++; if (valid_o !== 1'b1 || pc_o !== 32'h204) begin bad++; $display("FAIL redir_follow got=%b/%h exp=1/00000204", valid_o, pc_o); end
        step();
    endtask

    task automatic test_redirect_stall();
        stall_i = 1'b1; #1;
        total++; if (imem_rd_en_o !== 1'b0) begin bad++; $display("FAIL rs_fill_rd_en got=%b exp=0", imem_rd_en_o); end
        step(); #1;
        total++; if (valid_o !== 1'b1 || imem_rd_en_o !== 1'b0) begin bad++; $display("FAIL rs_full got=%b/%b exp=1/0", valid_o, imem_rd_en_o); end
        redirect_i = 1'b1; redirect_pc_i = 32'h300; #1;
        total++; if (imem_rd_en_o !== 1'b1 || imem_addr_o !== 32'h300) begin bad++; $display("FAIL rs_req got=%b/%h exp=1/00000300", imem_rd_en_o, imem_addr_o); end
        step(); redirect_i = 1'b0; stall_i = 1'b0; #1;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rs_bubble got=%b exp=0", valid_o); end
        step(); #1;
        total++; if (valid_o !== 1'b1 || pc_o !== 32'h300 || instr_o !== 32'hA5A5_0300) begin bad++; $display("FAIL rs_head got=%b/%h/%h exp=1/00000300/a5a50300", valid_o, pc_o, instr_o); end
        step(); #1;
        total++; if (pc_o !== 32'h304) begin bad++; $display("FAIL rs_follow got=%h exp=00000304", pc_o); end
        step();
    endtask

    task automatic test_wrap();
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; #1;
        total++; if (imem_addr_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req got=%h exp=fffffffc", imem_addr_o); end
        step(); redirect_i = 1'b0; #1;
        total++; if (imem_rd_en_o !== 1'b1 || imem_addr_o !== 32'h0) begin bad++; $display("FAIL wrap_next_addr got=%b/%h exp=1/00000000", imem_rd_en_o, imem_addr_o); end
        step(); #1;
        total++; if (valid_o !== 1'b1 || pc_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_head got=%b/%h exp=1/fffffffc", valid_o, pc_o); end
        total++; if (pc_plus4_o !== 32'h0) begin bad++; $display("FAIL wrap_pc4 got=%h exp=00000000", pc_plus4_o); end
        step(); #1;
        total++; if (pc_o !== 32'h0 || pc_plus4_o !== 32'h4) begin bad++; $display("FAIL wrap_follow got=%h/%h exp=00000000/00000004", pc_o, pc_plus4_o); end
        step();
    endtask

`ifdef IF_FETCH_MISALIGN_TRAP_EN
    task automatic test_misalign();
        redirect_i = 1'b1; redirect_pc_i = 32'h202; #1;
        total++; if (imem_rd_en_o !== 1'b0) begin bad++; $display("FAIL mis_no_req got=%b exp=0", imem_rd_en_o); end
        step(); redirect_i = 1'b0; #1;
        total++; if (misalign_o !== 1'b1 || valid_o !== 1'b0 || imem_rd_en_o !== 1'b0) begin bad++; $display("FAIL mis_halt got=%b/%b/%b exp=1/0/0", misalign_o, valid_o, imem_rd_en_o); end
        step(); #1;
        total++; if (misalign_o !== 1'b1 || valid_o !== 1'b0 || imem_rd_en_o !== 1'b0) begin bad++; $display("FAIL mis_hold got=%b/%b/%b exp=1/0/0", misalign_o, valid_o, imem_rd_en_o); end
        redirect_i = 1'b1; redirect_pc_i = 32'h300; #1;
        total++; if (imem_rd_en_o !== 1'b1 || imem_addr_o !== 32'h300) begin bad++; $display("FAIL mis_resume_req got=%b/%h exp=1/00000300", imem_rd_en_o, imem_addr_o); end
        step(); redirect_i = 1'b0; #1;
        total++; if (misalign_o !== 1'b0 || valid_o !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b/%b exp=0/0", misalign_o, valid_o); end
        step(); #1;
        total++; if (valid_o !== 1'b1 || pc_o !== 32'h300) begin bad++; $display("FAIL mis_resume_head got=%b/%h exp=1/00000300", valid_o, pc_o); end
        redirect_i = 1'b1; redirect_pc_i = 32'h202;
        step(); redirect_i = 1'b0;
        step(); #1;
        total++; if (misalign_o !== 1'b1) begin bad++; $display("FAIL mis_second got=%b exp=1", misalign_o); end
        rst = 1'b1;
        step(); rst = 1'b0; #1;
        total++; if (misalign_o !== 1'b0 || imem_rd_en_o !== 1'b1 || imem_addr_o !== 32'h100) begin bad++; $display("FAIL mis_reset got=%b/%b/%h exp=0/1/00000100", misalign_o, imem_rd_en_o, imem_addr_o); end
        step();
    endtask
`else
    task automatic test_low_bits_ignored();
        redirect_i = 1'b1; redirect_pc_i = 32'h202; #1;
        total++; if (imem_rd_en_o !== 1'b1 || imem_addr_o !== 32'h200) begin bad++; $display("FAIL mask_req got=%b/%h exp=1/00000200", imem_rd_en_o, imem_addr_o); end
        step(); redirect_i = 1'b0;
        step(); #1;
        total++; if (valid_o !== 1'b1 || pc_o !== 32'h200) begin bad++; $display("FAIL mask_head got=%b/%h exp=1/00000200", valid_o, pc_o); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_startup();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
`ifdef IF_FETCH_MISALIGN_TRAP_EN
        test_misalign();
`else
        test_low_bits_ignored();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
